traffic_ctrl: RTL
=================

TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIR, default 2, number of approach directions (2..8).
REQ-002 SHALL have parameter GREEN_MIN, default 3, minimum green duration in cycles (>=1).
REQ-003 SHALL have parameter YELLOW_CYC, default 1, yellow duration in cycles (>=1).
REQ-004 SHALL have parameter GREEN_MAX, default 8, maximum green duration in cycles (>=GREEN_MIN).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port req  input  NUM_DIR  per-direction vehicle request, level, sampled each edge.
REQ-008 SHALL have port green  output  NUM_DIR  one-hot-or-zero green lamp per direction, registered.
REQ-009 SHALL have port yellow  output  NUM_DIR  one-hot-or-zero yellow lamp per direction, registered.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE, registered.
REQ-011 SHALL have port pending  output  NUM_DIR  latched outstanding requests, registered.
REQ-012 SHALL treat a direction as red when neither its green nor its yellow bit is set.

Function
REQ-013 SHALL implement states IDLE, GREEN, YELLOW, ALL_RED.
REQ-014 SHALL set pending[i] at the edge after req[i] is sampled high, except for the direction currently in GREEN.
REQ-015 SHALL, in IDLE with any pending bit set, select the next direction round-robin, starting at the index after the last-served one, and enter GREEN at the next edge.
REQ-016 SHALL clear pending for the selected direction on the same edge GREEN is entered; req for another direction in that cycle still sets its bit.
REQ-017 SHALL hold GREEN for exactly GREEN_MIN cycles, then enter YELLOW (with the extension feature disabled).
REQ-018 SHALL hold YELLOW for exactly YELLOW_CYC cycles, then enter ALL_RED for exactly 1 cycle, then IDLE.
REQ-019 SHALL keep green and yellow all-zero in IDLE and ALL_RED; at most one bit of green|yellow set at any time.
REQ-020 SHALL give req-to-green latency of 2 edges from IDLE (pending at edge k, green at edge k+1).
REQ-021 SHALL ignore req for the green direction while in GREEN; SHALL latch it during YELLOW and ALL_RED.
REQ-022 SHALL, on simultaneous requests after reset, serve index 0 first, then ascending.
REQ-023 SHALL size the phase counter to clog2(max(GREEN_MAX,YELLOW_CYC)+1) bits and never wrap.

Reset
REQ-024 SHALL, on reset low, immediately force state IDLE, green=0, yellow=0, busy=0, pending=0, counter=0, round-robin pointer to last-served = NUM_DIR-1.
REQ-025 SHALL abandon any in-progress phase on reset mid-operation, with no yellow emitted.
REQ-026 SHALL resume normal operation on the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL, with TRAFFIC_EXTEND_EN defined, extend GREEN beyond GREEN_MIN cycle-by-cycle while req of the green direction is high and no other pending bit is set, up to GREEN_MAX total cycles.
REQ-028 SHALL, without TRAFFIC_EXTEND_EN, ignore GREEN_MAX and keep GREEN fixed at GREEN_MIN.

Structure
REQ-029 SHALL place the state enumeration and default parameter constants in shared package traffic_pkg.
REQ-030 SHALL implement the round-robin selection in sub-module rr_arbiter (inputs request vector and last index; outputs one-hot grant and index).

Verification (NUM_DIR=2, GREEN_MIN=3, YELLOW_CYC=1, GREEN_MAX=8)
REQ-031 SHALL cover: req=01 for 1 cycle from IDLE -> green=01 for 3 cycles, yellow=01 for 1 cycle, 1 all-red cycle, then IDLE with busy=0.
REQ-032 SHALL cover: req=01, then req=10 during dir-0 GREEN -> pending=10 held; after dir-0 ALL_RED, green=10 for 3 cycles.
REQ-033 SHALL cover: req=11 together right after reset -> dir 0 served first, then dir 1; the next simultaneous req=11 is served dir 0 first.
REQ-034 SHALL cover: reset low mid-GREEN -> green=00, pending=00, busy=0 without waiting for a clock edge.
REQ-035 SHALL cover, with TRAFFIC_EXTEND_EN: req=01 held high -> green=01 for 8 cycles; raising req=10 at green cycle 4 -> yellow starts after green cycle 4.
REQ-036 SHALL cover: all cycles check green|yellow is one-hot-or-zero.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encoding and default timing constants for the traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2,
    S_ALL_RED = 2'd3
  } state_t;

  localparam int DEF_NUM_DIR    = 2;
  localparam int DEF_GREEN_MIN  = 3;
  localparam int DEF_YELLOW_CYC = 1;
  localparam int DEF_GREEN_MAX  = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_ctrl_rr_arbiter.sv
// Round-robin picker: first set request strictly after the last-served index, wrapping.
module rr_arbiter
  import traffic_pkg::*;
#(
  parameter int NUM_DIR = DEF_NUM_DIR,
  parameter int IW      = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_DIR-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_vld
);

  int w_c;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_c   = 0;
    // The last-served index is visited last, so it only wins when nothing else asks.
    for (int off = 1; off <= NUM_DIR; off++) begin
      w_c = (int'(i_last) + off) % NUM_DIR;
      if (!o_vld && i_req[w_c]) begin
        o_vld      = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = IW'(w_c);
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Round-robin traffic light controller: IDLE -> GREEN -> YELLOW -> ALL_RED -> IDLE.
// Define TRAFFIC_EXTEND_EN to let an uncontested green stretch up to GREEN_MAX cycles.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = DEF_NUM_DIR,
  parameter int GREEN_MIN  = DEF_GREEN_MIN,
  parameter int YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int GREEN_MAX  = DEF_GREEN_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DIR-1:0] req,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic               busy,
  output logic [NUM_DIR-1:0] pending
);

  localparam int IW = $clog2(NUM_DIR);
  localparam int CW = $clog2(max2(GREEN_MAX, YELLOW_CYC) + 1);

  state_t             r_state, w_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_DIR-1:0] r_cur, w_cur_nxt;
  logic [NUM_DIR-1:0] r_pending, w_pend_nxt, w_mask, w_clr;
  logic [NUM_DIR-1:0] r_green, r_yellow;
  logic [NUM_DIR-1:0] w_gnt;
  logic [IW-1:0]      r_last, w_last_nxt, w_idx;
  logic               r_busy, w_vld, w_ext;

  rr_arbiter #(.NUM_DIR(NUM_DIR), .IW(IW)) u_arb (
    .i_req  (r_pending),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_vld  (w_vld)
  );

`ifdef TRAFFIC_EXTEND_EN
  // Live req of other directions counts as competition, so a new arrival ends the extension.
  logic [NUM_DIR-1:0] w_others;
  assign w_others = (r_pending | req) & ~r_cur;
  assign w_ext    = (|(req & r_cur)) && (w_others == '0) && (r_cnt < CW'(GREEN_MAX));
`else
  assign w_ext = 1'b0;
`endif

  always_comb begin
    w_nxt      = r_state;
    w_cnt_nxt  = r_cnt;
    w_cur_nxt  = r_cur;
    w_last_nxt = r_last;
    w_mask     = '0;
    w_clr      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_vld) begin
          w_nxt      = S_GREEN;
          w_cnt_nxt  = CW'(1);
          w_cur_nxt  = w_gnt;
          w_last_nxt = w_idx;
          w_clr      = w_gnt;
        end
      end
      S_GREEN: begin
        w_mask = r_cur;
        if (r_cnt >= CW'(GREEN_MIN) && !w_ext) begin
          w_nxt     = S_YELLOW;
          w_cnt_nxt = CW'(1);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_YELLOW: begin
        if (r_cnt >= CW'(YELLOW_CYC)) begin
          w_nxt     = S_ALL_RED;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ALL_RED: begin
        w_nxt     = S_IDLE;
        w_cnt_nxt = '0;
      end
      default: begin
        w_nxt     = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
    // Clearing the granted bit wins over a same-edge req from that direction.
    w_pend_nxt = (r_pending | (req & ~w_mask)) & ~w_clr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cur     <= '0;
      r_last    <= IW'(NUM_DIR - 1);
      r_pending <= '0;
      r_green   <= '0;
      r_yellow  <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur     <= w_cur_nxt;
      r_last    <= w_last_nxt;
      r_pending <= w_pend_nxt;
      r_green   <= (w_nxt == S_GREEN)  ? w_cur_nxt : '0;
      r_yellow  <= (w_nxt == S_YELLOW) ? w_cur_nxt : '0;
      r_busy    <= (w_nxt != S_IDLE);
    end
  end

  assign green   = r_green;
  assign yellow  = r_yellow;
  assign busy    = r_busy;
  assign pending = r_pending;

endmodule
